// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the sensor alarm controller.
package alarm_pkg;

    // FSM state encoding; the numeric values are visible on the state_o debug port.
    typedef enum logic [2:0] {
        StDisarmed   = 3'd0,
        StExitDelay  = 3'd1,
        StArmed      = 3'd2,
        StEntryDelay = 3'd3,
        StAlarm      = 3'd4
    } alarm_state_e;

    localparam int unsigned DefExitCycles  = 8;
    localparam int unsigned DefEntryCycles = 6;
    localparam int unsigned DefSirenCycles = 16;

    // Largest of the three delays; sizes the shared down-counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alarm_controller_majority_vote.sv
// 2-of-3 sensor vote: trips when at least two sensors agree.
module majority_vote (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/alarm_controller.sv
// Arm/disarm sequencer around the 2-of-3 sensor vote, with exit delay,
// entry delay and a timed siren that auto re-arms.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int unsigned EXIT_CYCLES  = DefExitCycles,
    parameter int unsigned ENTRY_CYCLES = DefEntryCycles,
    parameter int unsigned SIREN_CYCLES = DefSirenCycles
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_a,
    input  logic       sensor_b,
    input  logic       sensor_c,
    input  logic       arm_req,
    input  logic       disarm_req,
    output logic       siren,
    output logic       armed,
    output logic       pending,
    output logic       alarm_mem,
    output logic [2:0] state_o
);

    localparam int unsigned CNT_W = $clog2(max3(EXIT_CYCLES, ENTRY_CYCLES, SIREN_CYCLES) + 1);

    localparam logic [CNT_W-1:0] ExitLoad  = CNT_W'(EXIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] EntryLoad = CNT_W'(ENTRY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SirenLoad = CNT_W'(SIREN_CYCLES - 1);

    alarm_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sens_q;
    logic             mem_d;
    logic             vote;

    majority_vote u_vote (
        .a (sens_q[0]),
        .b (sens_q[1]),
        .c (sens_q[2]),
        .y (vote)
    );

    // Next-state, counter and sticky-alarm logic; disarm_req wins over everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = alarm_mem;
        case (state_q)
            StDisarmed: begin
                if (arm_req && !disarm_req) begin
                    state_d = StExitDelay;
                    cnt_d   = ExitLoad;
                    mem_d   = 1'b0;
                end
            end
            StExitDelay: begin
                if (disarm_req)          state_d = StDisarmed;
                else if (cnt_q == '0)    state_d = StArmed;
                else                     cnt_d   = cnt_q - 1'b1;
            end
            StArmed: begin
                if (disarm_req) begin
                    state_d = StDisarmed;
                end else if (vote) begin
                    state_d = StEntryDelay;
                    cnt_d   = EntryLoad;
                end
            end
            StEntryDelay: begin
                if (disarm_req) begin
                    state_d = StDisarmed;
                end else if (cnt_q == '0) begin
                    state_d = StAlarm;
                    cnt_d   = SirenLoad;
                    mem_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAlarm: begin
                if (disarm_req)          state_d = StDisarmed;
                else if (cnt_q == '0)    state_d = StArmed;
                else                     cnt_d   = cnt_q - 1'b1;
            end
            // Encodings 5-7 fall back to a safe disarmed state.
            default: begin
                state_d = StDisarmed;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, sensor sampling and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StDisarmed;
            cnt_q     <= '0;
            sens_q    <= '0;
            siren     <= 1'b0;
            armed     <= 1'b0;
            pending   <= 1'b0;
            alarm_mem <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sens_q    <= {sensor_c, sensor_b, sensor_a};
            siren     <= (state_d == StAlarm);
            armed     <= (state_d == StArmed) || (state_d == StEntryDelay) ||
                         (state_d == StAlarm);
            pending   <= (state_d == StExitDelay) || (state_d == StEntryDelay);
            alarm_mem <= mem_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Sequencing controller for the 2-of-3 sensor alarm. Sensors: A = door, B = window, C = presence.
- Registers the three sensor inputs and feeds them to a majority vote sub-module.
- Wraps the vote in an arm/disarm state machine with exit delay, entry delay and a timed siren.
- Top-level block between the panel inputs (arm/disarm keys, sensors) and the siren/LED outputs.

Parameters:
- EXIT_CYCLES, 8, cycles spent in EXIT_DELAY after arming before the system is armed; must be ≥1.
- ENTRY_CYCLES, 6, cycles from a valid trigger to siren activation; must be ≥1.
- SIREN_CYCLES, 16, cycles the siren stays on before automatic re-arm; must be ≥1.
- CNT_W, $clog2(max(EXIT,ENTRY,SIREN)+1), down-counter width; derived, not overridden.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, synchronous reset, active-low.
- sensor_a, input, 1, door sensor, 1 = tripped.
- sensor_b, input, 1, window sensor, 1 = tripped.
- sensor_c, input, 1, presence sensor, 1 = tripped.
- arm_req, input, 1, single-cycle arm request.
- disarm_req, input, 1, single-cycle disarm request.
- siren, output, 1, alarm output (the Y of the vote, gated by the FSM).
- armed, output, 1, armed indicator.
- pending, output, 1, a delay countdown is running.
- alarm_mem, output, 1, sticky flag: an alarm has occurred since the last arm.
- state_o, output, 3, current FSM state encoding, for debug/LEDs.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. rst_n=0 sampled at an edge forces:
  - state = DISARMED, counter = 0, sensor register = 0;
  - siren = 0, armed = 0, pending = 0, alarm_mem = 0.
  - Reset overrides everything, including mid-countdown and mid-siren.
- Sensor path:
  - sensor_a/b/c are registered every cycle into sens_q[2:0].
  - vote = (a&b)|(a&c)|(b&c) on sens_q, computed combinationally.
  - Latency from pins to FSM decision is 1 cycle.
- States and encoding: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4. Values 5-7 are illegal and recover to DISARMED on the next edge.
- DISARMED:
  - arm_req=1 → EXIT_DELAY, counter ← EXIT_CYCLES-1, alarm_mem ← 0.
  - Vote is ignored.
- EXIT_DELAY:
  - disarm_req → DISARMED.
  - Else if counter==0 → ARMED.
  - Else counter decrements.
  - Vote is ignored, so the state lasts exactly EXIT_CYCLES cycles.
- ARMED:
  - disarm_req → DISARMED.
  - Else if vote=1 → ENTRY_DELAY, counter ← ENTRY_CYCLES-1.
  - A single tripped sensor never triggers.
- ENTRY_DELAY:
  - disarm_req → DISARMED.
  - Else if counter==0 → ALARM, counter ← SIREN_CYCLES-1, alarm_mem ← 1.
  - Else counter decrements.
  - Vote dropping to 0 does not cancel the countdown.
- ALARM:
  - disarm_req → DISARMED.
  - Else if counter==0 → ARMED (auto re-arm).
  - Else counter decrements.
  - If the vote is still 1 after re-arm, the FSM enters ENTRY_DELAY on the next edge.
- Simultaneous events:
  - disarm_req has priority over arm_req, vote and counter expiry in every state.
  - arm_req is ignored outside DISARMED.
  - arm_req and disarm_req together in DISARMED → stays DISARMED.
- Outputs are registered, derived from the next state:
  - siren = (state==ALARM).
  - armed = state ∈ {ARMED, ENTRY_DELAY, ALARM}.
  - pending = state ∈ {EXIT_DELAY, ENTRY_DELAY}.
  - alarm_mem survives disarm; it clears only on an accepted arm_req or on reset.
- Counter arithmetic: unsigned, CNT_W bits. It is never decremented below 0 and holds its value in DISARMED and ARMED.

Decomposition:
- Shared package alarm_pkg:
  - state typedef/localparams (DISARMED..ALARM, 3-bit);
  - default delay constants.
- One sub-module: majority_vote (3 inputs → 1, purely combinational, the 2-of-3 alarm equation), instantiated on sens_q.
- The FSM, counter and input register stay in alarm_controller.

Test Plan (bench overrides EXIT=4, ENTRY=3, SIREN=5):
- Reset, then arm_req pulse at edge t → pending=1 for edges t+1..t+4; armed=1, pending=0 from edge t+5.
- Armed; sensor_a=1 and sensor_b=1 at edge e → ENTRY_DELAY after e+1 (pending=1); siren=1 after edge e+4 for exactly 5 cycles; then armed, siren=0, alarm_mem=1.
- Armed; only sensor_c=1 held for 20 cycles → state stays ARMED, siren=0.
- ENTRY_DELAY with disarm_req in the same cycle that the counter reaches 0 → DISARMED; siren never asserts; armed=0.
- ALARM; arm_req and disarm_req together → DISARMED, siren=0, alarm_mem stays 1; a later arm_req clears alarm_mem.
- rst_n=0 for one edge mid-siren → all outputs 0, state_o=0; the same sensor pattern afterwards does not trigger until re-armed.
